// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA table: operation enum, opcode/funct codes, field positions.
// Used by both the instruction encoder and the control decoder so the two agree.
// Pure declarations and combinational helpers; no state.
package mips_isa_pkg;

   // Operation index carried on the encoder input; values >= NUM_OPS are illegal.
   typedef enum logic [4:0] {
      OP_ADDU, OP_SUBU, OP_SLT, OP_SLL, OP_SRA, OP_JR,
      OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_LH, OP_LHU,
      OP_LB, OP_LBU, OP_SH, OP_SB, OP_JAL, OP_SLTIU
   } op_e;

   localparam int NUM_OPS = 19;

   // Primary opcodes
   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_ORI   = 6'b001101;
   localparam logic [5:0] OPC_LUI   = 6'b001111;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_LH    = 6'b100001;
   localparam logic [5:0] OPC_LHU   = 6'b100101;
   localparam logic [5:0] OPC_LB    = 6'b100000;
   localparam logic [5:0] OPC_LBU   = 6'b100100;
   localparam logic [5:0] OPC_SH    = 6'b101001;
   localparam logic [5:0] OPC_SB    = 6'b101000;
   localparam logic [5:0] OPC_SLTIU = 6'b001011;
   localparam logic [5:0] OPC_JAL   = 6'b000011;

   // R-type function codes
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRA  = 6'b000011;

   // Field LSB positions within the 32-bit word
   localparam int OPC_LSB = 26;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int RD_LSB  = 11;
   localparam int SH_LSB  = 6;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
      return (32'(OPC_RTYPE) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
             (32'(rd) << RD_LSB) | (32'(sh) << SH_LSB) | 32'(fn);
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm16);
      return (32'(opc) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm16);
   endfunction

   function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] tgt);
      return (32'(opc) << OPC_LSB) | 32'(tgt);
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input channel and encoded-word output channel, valid/ready each.
// No logic; latency defined by the endpoints.
// Backpressure: in_ready from the encoder, out_ready from the memory port.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [4:0]  in_shamt;
   logic [25:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;

   // Program generator side
   modport master (
      output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_addr
   );

   // Encoder side
   modport slave (
      input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_addr
   );
endinterface

// File: rtl/instr_pack.sv
// Maps an operation index plus register/immediate fields to a 32-bit MIPS word.
// Purely combinational, zero latency.
// No handshake; unused fields are zeroed, out-of-range ops give word 0 and illegal=1.
module instr_pack
   import mips_isa_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [25:0] imm,
   output logic [31:0] instr,
   output logic        illegal
);

   logic [15:0] imm16;
   assign imm16 = imm[15:0];

   // Select the format for each operation and keep only the fields it uses
   always_comb begin
      instr   = '0;
      illegal = (op >= 5'(NUM_OPS));
      case (op)
         OP_ADDU:  instr = r_word(rs, rt, rd, 5'd0, FN_ADDU);
         OP_SUBU:  instr = r_word(rs, rt, rd, 5'd0, FN_SUBU);
         OP_SLT:   instr = r_word(rs, rt, rd, 5'd0, FN_SLT);
         OP_SLL:   instr = r_word(5'd0, rt, rd, shamt, FN_SLL);
         OP_SRA:   instr = r_word(5'd0, rt, rd, shamt, FN_SRA);
         OP_JR:    instr = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
         OP_ORI:   instr = i_word(OPC_ORI, rs, rt, imm16);
         OP_LUI:   instr = i_word(OPC_LUI, 5'd0, rt, imm16);
         OP_LW:    instr = i_word(OPC_LW, rs, rt, imm16);
         OP_SW:    instr = i_word(OPC_SW, rs, rt, imm16);
         OP_BEQ:   instr = i_word(OPC_BEQ, rs, rt, imm16);
         OP_LH:    instr = i_word(OPC_LH, rs, rt, imm16);
         OP_LHU:   instr = i_word(OPC_LHU, rs, rt, imm16);
         OP_LB:    instr = i_word(OPC_LB, rs, rt, imm16);
         OP_LBU:   instr = i_word(OPC_LBU, rs, rt, imm16);
         OP_SH:    instr = i_word(OPC_SH, rs, rt, imm16);
         OP_SB:    instr = i_word(OPC_SB, rs, rt, imm16);
         OP_SLTIU: instr = i_word(OPC_SLTIU, rs, rt, imm16);
         OP_JAL:   instr = j_word(OPC_JAL, imm);
         default:  instr = '0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streaming encoder: field bundles in, packed words plus byte address out.
// Latency 1: a word accepted at edge N is on out_* after N, consumable at N+1.
// Backpressure: in_ready = !full & (!out_valid | out_ready); one word/cycle when drained.
module instr_encoder
   import mips_isa_pkg::*;
#(
   parameter int          IM_AW     = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   instr_encoder_if.slave bus,
   output logic          full,
   output logic          err_illegal
);

   typedef enum logic {OUT_EMPTY, OUT_HOLD} out_state_e;

   out_state_e     state_q, state_d;
   logic [31:0]    instr_q, instr_d;
   logic [31:0]    addr_q, addr_d;
   logic [IM_AW:0] cnt_q, cnt_d;
   logic           err_q, err_d;

   logic [31:0]    pack_instr;
   logic           pack_illegal;
   logic           accept;
   logic [31:0]    slot_addr;

   instr_pack u_pack (
      .op      (bus.in_op),
      .rs      (bus.in_rs),
      .rt      (bus.in_rt),
      .rd      (bus.in_rd),
      .shamt   (bus.in_shamt),
      .imm     (bus.in_imm),
      .instr   (pack_instr),
      .illegal (pack_illegal)
   );

   // The counter MSB is the full flag: it only sets once all 2^IM_AW slots are used
   assign full          = cnt_q[IM_AW];
   assign bus.in_ready  = !full && (state_q == OUT_EMPTY || bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;
   assign slot_addr     = BASE_ADDR + (32'(cnt_q[IM_AW-1:0]) << 2);

   assign bus.out_valid = (state_q == OUT_HOLD);
   assign bus.out_instr = instr_q;
   assign bus.out_addr  = addr_q;
   assign err_illegal   = err_q;

   // Next-state: flush wins; otherwise load on legal accept, drain on out_ready
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (flush) begin
         state_d = OUT_EMPTY;
         instr_d = '0;
         addr_d  = BASE_ADDR;
         cnt_d   = '0;
      end else begin
         if (accept && !pack_illegal) begin
            state_d = OUT_HOLD;
            instr_d = pack_instr;
            addr_d  = slot_addr;
            cnt_d   = cnt_q + {{IM_AW{1'b0}}, 1'b1};
         end else if (state_q == OUT_HOLD && bus.out_ready) begin
            state_d = OUT_EMPTY;
         end
         if (accept && pack_illegal) begin
            err_d = 1'b1;
         end
      end
   end

   // State register; reset drops any held word immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= OUT_EMPTY;
         instr_q <= '0;
         addr_q  <= BASE_ADDR;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder with a small (4-slot) memory.
// Directed scenarios followed by randomized traffic against a transaction-level model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_instr_encoder;
   import mips_isa_pkg::*;

   localparam int          AW   = 2;
   localparam int          CAP  = 4;
   localparam logic [31:0] BASE = 32'h0000_3000;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic flush = 1'b0;
   logic full;
   logic err_illegal;

   instr_encoder_if bus ();

   instr_encoder #(.IM_AW(AW), .BASE_ADDR(BASE)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .bus         (bus),
      .full        (full),
      .err_illegal (err_illegal)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: what the output register should hold and how many slots are used
   bit          m_vld;
   logic [31:0] m_instr;
   logic [31:0] m_addr;
   int          m_cnt;
   bit          m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Encoding table written straight from the instruction formats
   function automatic logic [31:0] ref_enc(input logic [4:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sh, input logic [25:0] imm);
      logic [15:0] i16;
      i16 = imm[15:0];
      case (op)
         OP_ADDU:  return {6'b000000, rs, rt, rd, 5'b0, 6'b100001};
         OP_SUBU:  return {6'b000000, rs, rt, rd, 5'b0, 6'b100011};
         OP_SLT:   return {6'b000000, rs, rt, rd, 5'b0, 6'b101010};
         OP_SLL:   return {6'b000000, 5'b0, rt, rd, sh, 6'b000000};
         OP_SRA:   return {6'b000000, 5'b0, rt, rd, sh, 6'b000011};
         OP_JR:    return {6'b000000, rs, 15'b0, 6'b001000};
         OP_ORI:   return {6'b001101, rs, rt, i16};
         OP_LUI:   return {6'b001111, 5'b0, rt, i16};
         OP_LW:    return {6'b100011, rs, rt, i16};
         OP_SW:    return {6'b101011, rs, rt, i16};
         OP_BEQ:   return {6'b000100, rs, rt, i16};
         OP_LH:    return {6'b100001, rs, rt, i16};
         OP_LHU:   return {6'b100101, rs, rt, i16};
         OP_LB:    return {6'b100000, rs, rt, i16};
         OP_LBU:   return {6'b100100, rs, rt, i16};
         OP_SH:    return {6'b101001, rs, rt, i16};
         OP_SB:    return {6'b101000, rs, rt, i16};
         OP_JAL:   return {6'b000011, imm};
         OP_SLTIU: return {6'b001011, rs, rt, i16};
         default:  return 32'h0;
      endcase
   endfunction

   task automatic m_reset();
      m_vld   = 0;
      m_instr = 32'h0;
      m_addr  = BASE;
      m_cnt   = 0;
      m_err   = 0;
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [25:0] imm, input logic ordy, input logic fl);
      bus.in_valid  = v;
      bus.in_op     = op;
      bus.in_rs     = rs;
      bus.in_rt     = rt;
      bus.in_rd     = rd;
      bus.in_shamt  = sh;
      bus.in_imm    = imm;
      bus.out_ready = ordy;
      flush         = fl;
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, ordy, 1'b0);
   endtask

   // One clock: check in_ready, advance model across the edge, then check outputs
   task automatic step();
      bit exp_rdy;
      bit acc;
      #1;
      exp_rdy = (m_cnt < CAP) && (!m_vld || bus.out_ready);
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
      @(posedge clk);
      acc = bus.in_valid && exp_rdy;
      if (flush) begin
         m_vld   = 0;
         m_cnt   = 0;
         m_instr = 32'h0;
         m_addr  = BASE;
      end else if (acc && bus.in_op < 5'd19) begin
         m_vld   = 1;
         m_instr = ref_enc(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_imm);
         m_addr  = BASE + 32'(4 * m_cnt);
         m_cnt++;
      end else begin
         if (acc) m_err = 1;
         if (m_vld && bus.out_ready) m_vld = 0;
      end
      #1;
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_vld});
      chk("full", {31'b0, full}, {31'b0, (m_cnt == CAP)});
      chk("err_illegal", {31'b0, err_illegal}, {31'b0, m_err});
      if (m_vld) begin
         chk("out_instr", bus.out_instr, m_instr);
         chk("out_addr", bus.out_addr, m_addr);
      end
   endtask

   task automatic do_flush();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b1);
      step();
      idle(1'b1);
   endtask

   initial begin
      logic [4:0] rop;
      m_reset();
      idle(1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'h0);
      chk("rst_out_addr", bus.out_addr, BASE);
      chk("rst_full", {31'b0, full}, 32'd0);
      chk("rst_err", {31'b0, err_illegal}, 32'd0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      reset = 1'b1;

      // addu then ori, back to back
      drive(1'b1, OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b1, 1'b0);
      step();
      chk("addu_word", bus.out_instr, 32'h00221821);
      chk("addu_addr", bus.out_addr, 32'h00003000);
      drive(1'b1, OP_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 26'h1234, 1'b1, 1'b0);
      step();
      chk("ori_word", bus.out_instr, 32'h34011234);
      chk("ori_addr", bus.out_addr, 32'h00003004);
      idle(1'b1);
      step();
      do_flush();

      // lui masks rs; sll
      drive(1'b1, OP_LUI, 5'd7, 5'd1, 5'd0, 5'd0, 26'h0FFFF, 1'b1, 1'b0);
      step();
      chk("lui_word", bus.out_instr, 32'h3C01FFFF);
      drive(1'b1, OP_SLL, 5'd0, 5'd1, 5'd2, 5'd4, 26'd0, 1'b1, 1'b0);
      step();
      chk("sll_word", bus.out_instr, 32'h00011100);
      do_flush();

      // jal held for 3 cycles of backpressure, then jr
      drive(1'b1, OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0000C03, 1'b0, 1'b0);
      step();
      chk("jal_word", bus.out_instr, 32'h0C000C03);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, OP_JR, 5'd31, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 1'b0);
         step();
         chk("jal_hold", bus.out_instr, 32'h0C000C03);
         chk("stall_rdy", {31'b0, bus.in_ready}, 32'd0);
      end
      drive(1'b1, OP_JR, 5'd31, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 1'b0);
      step();
      chk("jr_word", bus.out_instr, 32'h03E00008);
      do_flush();

      // fill all four slots; fifth attempt refused
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, OP_SW, 5'($urandom), 5'($urandom), 5'd0, 5'd0, 26'($urandom), 1'b1, 1'b0);
         step();
         if (i < 4) chk("fill_addr", bus.out_addr, BASE + 32'(4 * i));
         if (i == 3) chk("full_after4", {31'b0, full}, 32'd1);
      end
      chk("full_rdy", {31'b0, bus.in_ready}, 32'd0);
      do_flush();
      chk("flush_full", {31'b0, full}, 32'd0);
      drive(1'b1, OP_ADDU, 5'd4, 5'd5, 5'd6, 5'd0, 26'd0, 1'b1, 1'b0);
      step();
      chk("post_flush_addr", bus.out_addr, 32'h00003000);
      do_flush();

      // illegal op between two beq
      drive(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 26'd3, 1'b1, 1'b0);
      step();
      chk("beq1_word", bus.out_instr, 32'h10220003);
      chk("beq1_addr", bus.out_addr, 32'h00003000);
      drive(1'b1, 5'd25, 5'd1, 5'd2, 5'd0, 5'd0, 26'd3, 1'b1, 1'b0);
      step();
      chk("illegal_err", {31'b0, err_illegal}, 32'd1);
      drive(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 26'd3, 1'b1, 1'b0);
      step();
      chk("beq2_word", bus.out_instr, 32'h10220003);
      chk("beq2_addr", bus.out_addr, 32'h00003004);

      // reset pulsed while holding a word
      drive(1'b1, OP_SUBU, 5'd9, 5'd8, 5'd7, 5'd0, 26'd0, 1'b0, 1'b0);
      step();
      idle(1'b0);
      #1 reset = 1'b0;
      #1;
      chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("arst_out_addr", bus.out_addr, BASE);
      chk("arst_err", {31'b0, err_illegal}, 32'd0);
      m_reset();
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b1, OP_SLT, 5'd3, 5'd4, 5'd5, 5'd0, 26'd0, 1'b1, 1'b0);
      step();
      chk("arst_next_addr", bus.out_addr, BASE);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         rop = 5'($urandom_range(0, 21));
         if ($urandom_range(0, 49) == 0) rop = 5'd31;
         if ($urandom_range(0, 39) == 0)
            drive(1'b0, rop, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'($urandom), 1'b1);
         else
            drive(1'($urandom_range(0, 3) != 0), rop, 5'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom), 26'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming MIPS instruction encoder: accepts decoded instruction fields (operation code plus register and immediate fields) over a valid/ready handshake and emits packed 32-bit instruction words, each with the instruction-memory byte address it is written to. It is the inverse of the control decoder and sits between the self-test program generator and the instruction-memory write port. It covers the same 19-instruction subset the datapath executes.

## Interface
- `IM_AW`, 10: instruction-memory word-address width; capacity is 2^IM_AW words.
- `BASE_ADDR`, 32'h0000_3000: byte address of the first emitted word.
- `clk`  input  1  clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `flush`  input  1  synchronous; clears the address counter, the output register and `full`.
- `in_valid`  input  1  field bundle valid.
- `in_ready`  output  1  encoder can accept a bundle this cycle.
- `in_op`  input  5  operation index (package enum, 0..18).
- `in_rs`, `in_rt`, `in_rd`, `in_shamt`  input  5 each  register and shift fields.
- `in_imm`  input  26  imm16 in [15:0]; jump target in [25:0].
- `out_valid`  output  1  `out_instr`/`out_addr` valid.
- `out_ready`  input  1  memory port accepts the word.
- `out_instr`  output  32  encoded word.
- `out_addr`  output  32  byte address, `BASE_ADDR + 4*index`.
- `full`  output  1  all 2^IM_AW slots have been allocated.
- `err_illegal`  output  1  sticky; an out-of-range `in_op` was accepted.

## Operation
- Encodings:
  - R-type, opcode 0, funct: addu 100001, subu 100011, slt 101010, jr 001000, sll 000000, sra 000011.
  - I-type opcodes: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, lh 100001, lhu 100101, lb 100000, lbu 100100, sh 101001, sb 101000, sltiu 001011.
  - J-type: jal opcode 000011.
- Field use; unused fields are forced to zero in the output:
  - addu, subu and slt use rs, rt and rd.
  - sll and sra use rt, rd and shamt (rs = 0).
  - jr uses rs only.
  - lui uses rt and imm16 (rs = 0).
  - Other I-types use rs, rt and imm16.
  - jal uses target26.
- Accept on `in_valid & in_ready`.
  - Legal op: the word is loaded into the output register, `out_addr` is set to the current slot address, and the slot counter increments.
  - Illegal op (index ≥ 19): the bundle is consumed, nothing is emitted, the counter is unchanged, and `err_illegal` is set.
- `in_ready = !full & (!out_valid | out_ready)`. This gives back-to-back throughput of one word per cycle.
- Output register states:
  - EMPTY: `out_valid` = 0.
  - HOLD: `out_valid` = 1. `out_instr` and `out_addr` stay stable until `out_ready`.
  - Transitions:
    - EMPTY→HOLD on a legal accept.
    - HOLD→EMPTY on `out_ready` with no accept.
    - HOLD→HOLD on `out_ready` with a simultaneous legal accept; the register loads the new word.
- Counter is IM_AW+1 bits.
  - `full` asserts when the counter reaches 2^IM_AW and stays set until `flush` or reset.
  - No wrap-around; `out_addr` never exceeds `BASE_ADDR + 4*(2^IM_AW − 1)`.
  - A pending HOLD word still drains while `full` is set.
- `flush` has priority over an accept in the same cycle.
  - A held word is dropped.
  - `err_illegal` is not cleared by `flush`; only reset clears it.

## Timing
- Reset values: `out_valid` 0, `out_instr` 0, `out_addr` `BASE_ADDR`, `full` 0, `err_illegal` 0, counter 0. `in_ready` is 1 after reset.
- Latency: a word accepted at edge N is visible on `out_*` after edge N, and is consumable at edge N+1.
- Reset asserted mid-transfer: the held word is lost, and outputs take their reset values asynchronously.
- `in_ready` depends combinationally on `out_ready`. No other combinational input-to-output paths exist.

## Structure
- `mips_isa_pkg` holds:
  - the operation enum (ADDU..SLTIU, 19 entries);
  - opcode and funct localparams;
  - the instruction-format field bit positions.
  - The control decoder uses the same package so that both ends share one table.
- Sub-module `instr_pack`: purely combinational; maps op plus fields to a 32-bit word and an `illegal` flag. The top level holds the handshake, the counter and the state.

## Test plan
- addu rs=1 rt=2 rd=3, then ori rs=0 rt=1 imm=0x1234, with `out_ready`=1 → 0x00221821 @0x3000, then 0x34011234 @0x3004 on consecutive cycles.
- lui rt=1 imm=0xFFFF with rs=7 applied, then sll rt=1 rd=2 shamt=4 → 0x3C01FFFF (rs masked), then 0x00011100.
- jal imm=0x0000C03, then jr rs=31 with `out_ready` held low for 3 cycles → 0x0C000C03 stable for 3 cycles, `in_ready`=0, then 0x03E00008.
- in_op=25 between two beq rs=1 rt=2 imm=3 bundles → `err_illegal`=1; two 0x10220003 words appear at consecutive addresses 0x3000 and 0x3004.
- IM_AW=2 with 5 accepts attempted → four words at 0x3000–0x300C, `full`=1 after the 4th, the 5th is not accepted; `flush` → `full`=0, next word @0x3000.
- Reset pulsed while in HOLD → `out_valid` drops immediately; the next accept is emitted @`BASE_ADDR`.
